ccd_frame_capture: RTL and testbench
====================================

// Module: ccd_frame_capture
// PURPOSE
//  Front-end capture stage feeding image_processing_module. Takes raw Bayer pixels plus
//  frame/line valid strobes from the D5M sensor interface; emits iDATA/iDVAL/iX_Cont/iY_Cont-
//  style stream (12-bit pixel, valid, column/row coordinates). Gates capture on start/end
//  commands so only whole frames reach the Sobel path. Counts completed frames.
// PARAMETERS
//  DATA_W        12    pixel width
//  COORD_W       11    width of X/Y coordinate outputs
//  COLUMN_WIDTH  1280  pixels per line; X wraps here
//  FRAME_CNT_W   32    width of completed-frame counter
// PORTS
//  iCLK         in   1            pixel clock; single clock domain
//  iRST         in   1            reset, asynchronous, active-high
//  iDATA        in   DATA_W       raw sensor pixel
//  iFVAL        in   1            sensor frame valid
//  iLVAL        in   1            sensor line valid
//  iSTART       in   1            1-cycle pulse: begin capturing at next frame start
//  iEND         in   1            1-cycle pulse: stop after current frame completes
//  oDATA        out  DATA_W       captured pixel (to image_processing_module iDATA)
//  oDVAL        out  1            pixel valid (to iDVAL)
//  oX_Cont      out  COORD_W      column of pixel on oDATA
//  oY_Cont      out  COORD_W      row of pixel on oDATA
//  oFrame_Cont  out  FRAME_CNT_W  completed frames since reset
//  oBusy        out  1            high whenever state != IDLE
// BEHAVIOUR
//  - Reset (async, iRST=1): all outputs 0, state IDLE, stop request cleared, counters 0.
//  - Stage 1 registers iDATA/iFVAL/iLVAL; stage 2 drives outputs. Latency iDATA->oDATA = 2 clk.
//  - FSM: IDLE -iSTART-> ARMED; ARMED -FVAL rise (stage-1 0->1)-> CAPTURE;
//    CAPTURE -FVAL fall-> ARMED, or IDLE if stop request set. iEND in ARMED -> IDLE at once.
//    iEND in CAPTURE sets stop request; frame finishes. iSTART+iEND same cycle: iEND wins.
//    iSTART in ARMED/CAPTURE ignored (but clears no pending stop).
//  - oDVAL=1 only in CAPTURE with stage-1 FVAL & LVAL high; a frame already in progress when
//    ARMED is entered is skipped entirely (no partial frames).
//  - X: 0 on first pixel of each line; +1 per valid pixel; at COLUMN_WIDTH-1 wraps to 0 and Y+1.
//    LVAL falling with X!=0 (short line): X->0, Y+1. Y wraps naturally at 2^COORD_W.
//  - FVAL fall in CAPTURE: oFrame_Cont+1 (wraps at 2^FRAME_CNT_W), X=Y=0.
//  - When oDVAL=0, oDATA/oX_Cont/oY_Cont hold last value. oBusy registered with state.
//  - FVAL fall without LVAL fall: treated as end-of-line then end-of-frame, same cycle.
// CONFIGURATION
//  CCD_CAPTURE_TEST_PATTERN_EN defined: iDATA ignored; oDATA = 100 when oY_Cont<4, else 500;
//    timing, valid and coordinates unchanged (still driven by iFVAL/iLVAL).
//  Undefined: oDATA = registered iDATA.
// STRUCTURE
//  Package ccd_capture_pkg: DATA_W/COORD_W/COLUMN_WIDTH defaults, cap_state_t enum
//    {IDLE, ARMED, CAPTURE}, TP_DARK=12'd100, TP_BRIGHT=12'd500.
//  Sub-module ccd_coord_counter: X/Y counters with wrap, short-line and frame-clear inputs.
// TESTING
//  1 iSTART, then 6 lines x 1280 px (iDATA=c) in one FVAL -> 7680 oDVAL beats, X 0..1279,
//    Y 0..5, first oDATA 2 clk after first iLVAL, oFrame_Cont=1, oBusy=1.
//  2 iSTART asserted mid-frame -> no oDVAL that frame; next full frame captured, count+1.
//  3 iEND during line 3 -> rest of frame captured, then IDLE, oBusy=0; next frame no oDVAL.
//  4 Line of 1000 px then LVAL low -> next line starts X=0, Y+1; 1300-px line -> X wraps
//    at 1279, Y increments twice.
//  5 iRST pulsed mid-line -> outputs 0 immediately; no capture until new iSTART + FVAL rise.
//  6 With CCD_CAPTURE_TEST_PATTERN_EN: 6x1280 frame -> oDATA 100 rows 0-3, 500 rows 4-5.

Source files
------------

// File: rtl/ccd_capture_pkg.sv
// Shared types and defaults for the CCD frame capture front end.
// Test-pattern pixel levels are used when CCD_CAPTURE_TEST_PATTERN_EN is defined.
package ccd_capture_pkg;

    localparam int DEF_DATA_W       = 12;
    localparam int DEF_COORD_W      = 11;
    localparam int DEF_COLUMN_WIDTH = 1280;
    localparam int DEF_FRAME_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } cap_state_t;

    localparam logic [11:0] TP_DARK   = 12'd100;
    localparam logic [11:0] TP_BRIGHT = 12'd500;

    function automatic logic [11:0] tp_pixel(input logic dark_row);
        return dark_row ? TP_DARK : TP_BRIGHT;
    endfunction

endpackage

// File: rtl/ccd_coord_counter.sv
// Column/row counter for captured pixels: wraps X at the line width,
// closes short lines on LVAL fall and clears both axes at end of frame.
module ccd_coord_counter
    import ccd_capture_pkg::*;
#(
    parameter int COORD_W      = DEF_COORD_W,
    parameter int COLUMN_WIDTH = DEF_COLUMN_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    input  logic               line_end,
    input  logic               frame_clear,
    output logic [COORD_W-1:0] x_cnt,
    output logic [COORD_W-1:0] y_cnt
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(COLUMN_WIDTH - 1);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

    // Next column/row; x_q always holds the column the next valid pixel will get.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_clear) begin
            x_d = '0;
            y_d = '0;
        end else if (pix_valid) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + ONE;
            end else begin
                x_d = x_q + ONE;
                y_d = y_q;
            end
        end else if (line_end && (x_q != '0)) begin
            x_d = '0;
            y_d = y_q + ONE;
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_cnt = x_q;
    assign y_cnt = y_q;

endmodule

// File: rtl/ccd_frame_capture.sv
// Capture stage between the D5M sensor interface and image_processing_module:
// passes only whole frames between start/end commands. Option: CCD_CAPTURE_TEST_PATTERN_EN.
module ccd_frame_capture
    import ccd_capture_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int COORD_W      = DEF_COORD_W,
    parameter int COLUMN_WIDTH = DEF_COLUMN_WIDTH,
    parameter int FRAME_CNT_W  = DEF_FRAME_CNT_W
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [DATA_W-1:0]      iDATA,
    input  logic                   iFVAL,
    input  logic                   iLVAL,
    input  logic                   iSTART,
    input  logic                   iEND,
    output logic [DATA_W-1:0]      oDATA,
    output logic                   oDVAL,
    output logic [COORD_W-1:0]     oX_Cont,
    output logic [COORD_W-1:0]     oY_Cont,
    output logic [FRAME_CNT_W-1:0] oFrame_Cont,
    output logic                   oBusy
);

    cap_state_t state_q, state_d;
    logic stop_q, stop_d, stop_set;
    logic fval1_q, lval1_q, fval2_q, lval2_q;
    logic fval_rise, fval_fall, lval_fall;
    logic pix_valid, line_end, frame_end;
    logic [COORD_W-1:0] x_cnt, y_cnt;
    logic dval_q, dval_d, busy_q, busy_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`ifndef CCD_CAPTURE_TEST_PATTERN_EN
    logic [DATA_W-1:0] data1_q;

    // Stage-1 pixel register.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            data1_q <= '0;
        end else begin
            data1_q <= iDATA;
        end
    end
`endif

    // Stage-1 strobes plus one extra tap for edge detection.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            fval1_q <= 1'b0;
            lval1_q <= 1'b0;
            fval2_q <= 1'b0;
            lval2_q <= 1'b0;
        end else begin
            fval1_q <= iFVAL;
            lval1_q <= iLVAL;
            fval2_q <= fval1_q;
            lval2_q <= lval1_q;
        end
    end

    // Edges of the stage-1 strobes.
    always_comb begin
        fval_rise = fval1_q & ~fval2_q;
        fval_fall = ~fval1_q & fval2_q;
        lval_fall = ~lval1_q & lval2_q;
    end

    // Capture FSM; iEND always beats iSTART, and a stop request only lives outside IDLE.
    always_comb begin
        state_d  = state_q;
        stop_set = stop_q;
        case (state_q)
            IDLE: begin
                if (iEND) state_d = IDLE;
                else if (iSTART) state_d = ARMED;
                else state_d = IDLE;
            end
            ARMED: begin
                if (iEND) state_d = IDLE;
                else if (fval_rise) state_d = CAPTURE;
                else state_d = ARMED;
            end
            CAPTURE: begin
                stop_set = stop_q | iEND;
                if (fval_fall) state_d = stop_set ? IDLE : ARMED;
                else state_d = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
        stop_d    = (state_d == IDLE) ? 1'b0 : stop_set;
        // Entering CAPTURE on the rise cycle lets a line that starts with the frame keep pixel 0.
        pix_valid = (state_d == CAPTURE) & fval1_q & lval1_q;
        line_end  = (state_q == CAPTURE) & lval_fall;
        frame_end = (state_q == CAPTURE) & fval_fall;
    end

    // FSM state and stop request.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= IDLE;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
        end
    end

    ccd_coord_counter #(
        .COORD_W      (COORD_W),
        .COLUMN_WIDTH (COLUMN_WIDTH)
    ) u_coord (
        .clk         (iCLK),
        .rst         (iRST),
        .pix_valid   (pix_valid),
        .line_end    (line_end),
        .frame_clear (frame_end),
        .x_cnt       (x_cnt),
        .y_cnt       (y_cnt)
    );

    // Stage-2 output values; data and coordinates hold while no pixel is valid.
    always_comb begin
        dval_d = pix_valid;
        busy_d = (state_d != IDLE);
        data_d = data_q;
        x_d    = x_q;
        y_d    = y_q;
        if (pix_valid) begin
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
            data_d = DATA_W'(tp_pixel(y_cnt < COORD_W'(4)));
`else
            data_d = data1_q;
`endif
            x_d = x_cnt;
            y_d = y_cnt;
        end else begin
            data_d = data_q;
            x_d    = x_q;
            y_d    = y_q;
        end
        if (frame_end) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        else frame_cnt_d = frame_cnt_q;
    end

    // Stage-2 output registers.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            dval_q      <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
        end else begin
            dval_q      <= dval_d;
            busy_q      <= busy_d;
            data_q      <= data_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = x_q;
    assign oY_Cont     = y_q;
    assign oFrame_Cont = frame_cnt_q;
    assign oBusy       = busy_q;

endmodule

// File: tb/tb_ccd_frame_capture.sv
// Randomized frame-level bench for ccd_frame_capture with a scoreboard of expected pixel beats.
// Build with CCD_CAPTURE_TEST_PATTERN_EN to check the test-pattern data path instead.
module tb_ccd_frame_capture;

    localparam int CW = 1280;

    logic        iCLK = 1'b0;
    logic        iRST, iFVAL, iLVAL, iSTART, iEND;
    logic [11:0] iDATA;
    logic [11:0] oDATA;
    logic        oDVAL, oBusy;
    logic [10:0] oX_Cont, oY_Cont;
    logic [31:0] oFrame_Cont;

    ccd_frame_capture dut (
        .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iFVAL(iFVAL), .iLVAL(iLVAL),
        .iSTART(iSTART), .iEND(iEND), .oDATA(oDATA), .oDVAL(oDVAL),
        .oX_Cont(oX_Cont), .oY_Cont(oY_Cont), .oFrame_Cont(oFrame_Cont), .oBusy(oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct packed {
        logic [11:0] d;
        logic [10:0] x;
        logic [10:0] y;
    } beat_t;

    beat_t exp_q[$];
    beat_t e;
    int fl[$];
    int n_cmp = 0, n_fail = 0, cyc = 0;
    int seg_beats = 0, seg_first_cyc = 0, seg_last_x = 0, seg_last_y = 0;
    int seg_first_d = 0, seg_last_d = 0, t_lval = 0;
    logic [11:0] last_d = 12'd0;
    // model: mode 0 idle, 1 armed, 2 capturing the current frame
    int m_mode = 0, m_stop = 0, m_frames = 0, mx = 0, my = 0;

    task automatic check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    function automatic int exp_pix(input int raw, input int y);
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
        return (y < 4) ? 100 : 500;
`else
        return raw;
`endif
    endfunction

    task automatic model_push(input int raw);
        if (m_mode == 2) begin
            exp_q.push_back('{d: 12'(exp_pix(raw, my)), x: 11'(mx), y: 11'(my)});
            mx++;
            if (mx == CW) begin
                mx = 0;
                my = (my + 1) % 2048;
            end
        end
    endtask

    task automatic model_line_end();
        if (m_mode == 2 && mx != 0) begin
            mx = 0;
            my = (my + 1) % 2048;
        end
    endtask

    task automatic model_cmd(input int kind);
        if (kind == 1) begin
            if (m_mode == 0) m_mode = 1;
        end else if (kind == 2 || kind == 4) begin
            if (m_mode == 1) m_mode = 0;
            else if (m_mode == 2) m_stop = 1;
        end
    endtask

    task automatic drive_cmd(input int kind);
        iSTART = (kind == 1 || kind == 4);
        iEND   = (kind == 2 || kind == 4);
    endtask

    task automatic cmd(input int kind);
        drive_cmd(kind);
        model_cmd(kind);
        tick();
        iSTART = 1'b0;
        iEND   = 1'b0;
    endtask

    // cmd_kind: 0 none, 1 start, 2 end, 3 reset pulse, 4 start+end
    task automatic run_frame(input int cmd_line, input int cmd_px, input int cmd_kind,
                             input bit abrupt, input bit col_data);
        int raw;
        seg_beats = 0;
        iFVAL = 1'b1;
        if (m_mode == 1) m_mode = 2;
        mx = 0;
        my = 0;
        tick();
        tick();
        for (int i = 0; i < fl.size(); i++) begin
            for (int p = 0; p < fl[i]; p++) begin
                raw   = col_data ? (p % 4096) : int'($urandom_range(0, 4095));
                iLVAL = 1'b1;
                iDATA = 12'(raw);
                if (i == 0 && p == 0) t_lval = cyc;
                if (i == cmd_line && p == cmd_px) begin
                    if (cmd_kind == 3) begin
                        iRST = 1'b1;
                        #1;
                        check("reset_async_outputs_zero",
                              longint'(|{oDATA, oDVAL, oX_Cont, oY_Cont, oFrame_Cont, oBusy}), 0);
                        exp_q.delete();
                        m_mode = 0;
                        m_stop = 0;
                        m_frames = 0;
                        tick();
                        iRST = 1'b0;
                    end else begin
                        drive_cmd(cmd_kind);
                        model_cmd(cmd_kind);
                    end
                end
                model_push(raw);
                tick();
                iSTART = 1'b0;
                iEND   = 1'b0;
            end
            if (!(abrupt && i == fl.size() - 1)) begin
                iLVAL = 1'b0;
                model_line_end();
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        iFVAL = 1'b0;
        iLVAL = 1'b0;
        model_line_end();
        if (m_mode == 2) begin
            m_frames++;
            m_mode = m_stop ? 0 : 1;
            m_stop = 0;
        end
        repeat (6) tick();
        check("beats_drained", exp_q.size(), 0);
        check("frame_count", oFrame_Cont, m_frames);
        check("busy", oBusy, (m_mode != 0));
    endtask

    task automatic set_lines(input int n, input int len);
        fl.delete();
        for (int i = 0; i < n; i++) fl.push_back(len);
    endtask

    initial forever begin
        @(posedge iCLK);
        cyc++;
    end

    // scoreboard compare on the falling edge
    initial forever begin
        @(negedge iCLK);
        if (iRST) begin
            last_d = 12'd0;
        end else if (oDVAL) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got d=%0d x=%0d y=%0d, required no beat",
                         oDATA, oX_Cont, oY_Cont);
            end else begin
                e = exp_q.pop_front();
                if ({oDATA, oX_Cont, oY_Cont} !== e) begin
                    n_fail++;
                    $display("FAIL beat: got d=%0d x=%0d y=%0d, required d=%0d x=%0d y=%0d",
                             oDATA, oX_Cont, oY_Cont, e.d, e.x, e.y);
                end
            end
            if (seg_beats == 0) begin
                seg_first_cyc = cyc;
                seg_first_d   = oDATA;
            end
            seg_beats++;
            seg_last_x = oX_Cont;
            seg_last_y = oY_Cont;
            seg_last_d = oDATA;
            last_d     = oDATA;
        end else begin
            n_cmp++;
            if (oDATA !== last_d) begin
                n_fail++;
                $display("FAIL data_hold: got %0d, required %0d", oDATA, last_d);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lines, kind, cl, cp;
        iRST = 1'b1; iFVAL = 1'b0; iLVAL = 1'b0; iSTART = 1'b0; iEND = 1'b0; iDATA = 12'd0;
        #22;
        check("reset_dval", oDVAL, 0);
        check("reset_data", oDATA, 0);
        check("reset_x", oX_Cont, 0);
        check("reset_y", oY_Cont, 0);
        check("reset_frames", oFrame_Cont, 0);
        check("reset_busy", oBusy, 0);
        @(negedge iCLK);
        iRST = 1'b0;
        tick();

        // no start command: nothing captured
        set_lines(3, 20);
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        check("idle_no_beats", seg_beats, 0);

        // full 6x1280 frame
        cmd(1);
        check("busy_after_start", oBusy, 1);
        set_lines(6, 1280);
        run_frame(-1, 0, 0, 1'b0, 1'b1);
        check("t1_beats", seg_beats, 7680);
        check("t1_last_x", seg_last_x, 1279);
        check("t1_last_y", seg_last_y, 5);
        check("t1_latency", seg_first_cyc - t_lval, 2);
        check("t1_frames", oFrame_Cont, 1);
        check("t1_busy", oBusy, 1);
`ifdef CCD_CAPTURE_TEST_PATTERN_EN
        check("t6_first_data", seg_first_d, 100);
        check("t6_last_data", seg_last_d, 500);
`else
        check("t1_first_data", seg_first_d, 0);
        check("t1_last_data", seg_last_d, 1279);
`endif

        // end while armed, then start mid-frame: that frame skipped, next captured
        cmd(2);
        check("end_in_armed_busy", oBusy, 0);
        set_lines(4, 40);
        run_frame(1, 5, 1, 1'b0, 1'b0);
        check("t2_skipped_beats", seg_beats, 0);
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        check("t2_beats", seg_beats, 160);
        check("t2_frames", oFrame_Cont, 2);

        // end during line 3: frame completes, then idle
        set_lines(5, 60);
        run_frame(2, 10, 2, 1'b0, 1'b0);
        check("t3_beats", seg_beats, 300);
        check("t3_frames", oFrame_Cont, 3);
        check("t3_busy", oBusy, 0);
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        check("t3_after_beats", seg_beats, 0);
        cmd(4);
        check("start_end_same_cycle_busy", oBusy, 0);

        // short line and overlong line
        cmd(1);
        fl = '{1000, 1300, 5};
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        check("t4_beats", seg_beats, 2305);
        check("t4_last_x", seg_last_x, 4);
        check("t4_last_y", seg_last_y, 3);
        fl = '{30, 17};
        run_frame(-1, 0, 0, 1'b1, 1'b0);
        check("abrupt_beats", seg_beats, 47);
        check("abrupt_last_x", seg_last_x, 16);
        check("abrupt_last_y", seg_last_y, 1);
        fl = '{10};
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        check("after_abrupt_last_y", seg_last_y, 0);
        check("t4_frames", oFrame_Cont, 6);

        // reset mid-line
        set_lines(4, 40);
        run_frame(1, 7, 3, 1'b0, 1'b0);
        check("t5_frames", oFrame_Cont, 0);
        check("t5_busy", oBusy, 0);
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        check("t5_no_beats", seg_beats, 0);
        cmd(1);
        run_frame(-1, 0, 0, 1'b0, 1'b0);
        check("t5_recapture_beats", seg_beats, 160);
        check("t5_recapture_frames", oFrame_Cont, 1);

        // randomized frames and commands
        for (int it = 0; it < 10; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5) cmd(1);
            else if (kind < 7) cmd(2);
            else if (kind == 7) cmd(4);
            lines = $urandom_range(1, 4);
            fl.delete();
            for (int i = 0; i < lines; i++)
                fl.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1270, 1300)
                                                         : $urandom_range(1, 150));
            cl = $urandom_range(0, lines - 1);
            cp = $urandom_range(0, fl[cl] - 1);
            run_frame(cl, cp, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
